uart_tx_drain: RTL and testbench
================================

// Module: uart_tx_drain
// PURPOSE
// UART transmitter that drains the receive FIFO (downstream of the FIFO's data_o/rd_en/empty interface).
// While enabled and the FIFO is non-empty, it pops one byte, serialises it as 8N1, LSB first, on tx_serial, then repeats.
// Provides the echo/forwarding path of the UART-GPIO top level; runs at the same bit timing as the RX side.
// PARAMETERS
// CLKS_PER_BIT  434  clk cycles per UART bit (100 MHz / 230400 baud); legal range >= 2
// DATA_BITS     8    payload bits per frame
// STOP_BITS     1    stop bits per frame, 1 or 2
// PORTS
// clk        in   1          system clock, all logic on rising edge
// rst        in   1          synchronous active-high reset
// tx_en_i    in   1          level enable; 0 = do not start new frames
// empty_i    in   1          FIFO empty flag
// data_i     in   DATA_BITS  FIFO read data, valid 1 cycle after rd_en_o
// rd_en_o    out  1          FIFO pop strobe, single-cycle pulse
// tx_serial  out  1          UART line, idle high
// busy_o     out  1          high from pop until end of last stop bit
// done_o     out  1          1-cycle pulse after the last stop bit completes
// BEHAVIOUR
// Reset: tx_serial=1, rd_en_o=0, busy_o=0, done_o=0, state=IDLE, bit counter=0, baud counter=0.
// Reset mid-frame aborts immediately; tx_serial returns high on the next edge and the popped byte is discarded.
// FSM states: IDLE, POP, LOAD, START, DATA, STOP, DONE.
//  IDLE : if tx_en_i && !empty_i then rd_en_o=1 for this one cycle -> POP; else remain in IDLE.
//  POP  : wait one cycle for FIFO read latency -> LOAD.
//  LOAD : shift register <= data_i; -> START.
//  START: tx_serial=0 for CLKS_PER_BIT cycles -> DATA.
//  DATA : tx_serial=shreg[0]; after CLKS_PER_BIT cycles shift right, bit_cnt++;
//         after DATA_BITS bits -> STOP.
//  STOP : tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles -> DONE.
//  DONE : done_o=1 for one cycle -> IDLE. A new frame may be popped on the next cycle (no extra gap).
// Latency: rd_en_o in cycle N -> start bit begins driving at edge N+3 (one cycle each for POP and LOAD).
// Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles; 8N1 @434 = 4340 cycles.
// Baud counter: counts 0..CLKS_PER_BIT-1, clears on every state change; width $clog2(CLKS_PER_BIT).
// Bit counter: width $clog2(DATA_BITS+1); no wrap beyond DATA_BITS.
// tx_en_i deasserted mid-frame: the current frame completes; no new pop follows.
// rd_en_o is never asserted while empty_i=1 or while busy_o=1, so the FIFO is never underflowed.
// empty_i changing during a frame is ignored until IDLE.
// busy_o = (state != IDLE) && (state != DONE); outputs are registered (tx_serial glitch-free).
// STRUCTURE
// Shared package uart_pkg: CLKS_PER_BIT default, state encoding localparams (3-bit), frame-length constant.
// One natural sub-module: uart_baud_tick (counter producing a bit-end tick, cleared on state change);
// a tick generator may also be shared with the RX side. FSM, shift register, bit counter live in this module.
// TESTING
// 1) Reset, empty_i=1, tx_en_i=1 for 10000 cycles -> tx_serial stays 1, rd_en_o never pulses.
// 2) Model FIFO preloaded with 0xF2 -> exactly one rd_en_o pulse; line 0,0,1,0,0,1,1,1,1,1 at 434-cycle bits; done_o pulses once.
// 3) FIFO holds 0x55,0xA3 -> two back-to-back frames, second start bit within 3 cycles of first done_o; FIFO ends empty.
// 4) tx_en_i=0 with data 0x3C -> no pop; raise tx_en_i -> frame 0x3C sent; drop tx_en_i at data bit 3 -> frame finishes, no further pop.
// 5) rst=1 during data bit 5 of 0xFF -> tx_serial=1 next cycle, busy_o=0, no done_o; after release the next byte is sent intact.
// 6) STOP_BITS=2, CLKS_PER_BIT=4 -> frame for 0x81 is 44 cycles, stop high for 8 cycles; a scoreboard RX model decodes all bytes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM encoding shared by the UART TX/RX blocks.
// Defaults target 100 MHz / 230400 baud, 8N1.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 434;
   localparam int DATA_BITS_DEF    = 8;
   localparam int STOP_BITS_DEF    = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5,
      ST_DONE  = 3'd6
   } tx_state_e;

   function automatic int frame_cycles(
      input int cpb,
      input int db,
      input int sb
   );
      return (1 + db + sb) * cpb;
   endfunction

   localparam int FRAME_CYCLES_DEF =
      (1 + DATA_BITS_DEF + STOP_BITS_DEF) * CLKS_PER_BIT_DEF;

endpackage

// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: FIFO read port seen by the TX drain.
// master = drain (issues pops), slave = FIFO.
interface uart_tx_drain_if #(
   parameter int DATA_BITS = 8
);

   logic                 empty_i;
   logic [DATA_BITS-1:0] data_i;
   logic                 rd_en_o;

   modport master (
      input  empty_i,
      input  data_i,
      output rd_en_o
   );

   modport slave (
      output empty_i,
      output data_i,
      input  rd_en_o
   );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter; tick_o marks the last cycle
// of a bit. Restarts from zero whenever clr_i is high.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from the RX FIFO and serialises them
// LSB first with one start and STOP_BITS stop bits on tx_serial.
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF,
   parameter int STOP_BITS    = STOP_BITS_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tx_en_i,
   uart_tx_drain_if.master fifo,
   output logic            tx_serial,
   output logic            busy_o,
   output logic            done_o
);

   localparam int BW = $clog2(DATA_BITS + 1);

   tx_state_e            state_q;
   tx_state_e            state_d;
   logic [DATA_BITS-1:0] shreg_q;
   logic [DATA_BITS-1:0] shreg_d;
   logic [BW-1:0]        bit_cnt_q;
   logic [BW-1:0]        bit_cnt_d;
   logic                 tx_q;
   logic                 tx_d;
   logic                 rd_en_q;
   logic                 rd_en_d;
   logic                 busy_q;
   logic                 busy_d;
   logic                 done_q;
   logic                 done_d;
   logic                 tick;
   logic                 st_chg;

   assign st_chg = (state_d != state_q);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clr_i (st_chg),
      .tick_o(tick)
   );

   // Line outputs follow the current state one cycle later, so the
   // start bit lands three edges after the pop strobe.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      rd_en_d   = 1'b0;
      tx_d      = 1'b1;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (tx_en_i && !fifo.empty_i) begin
               rd_en_d = 1'b1;
               state_d = ST_POP;
            end
         end
         ST_POP: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            shreg_d   = fifo.data_i;
            bit_cnt_d = '0;
            state_d   = ST_START;
         end
         ST_START: begin
            tx_d = 1'b0;
            if (tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_d = shreg_q[0];
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign fifo.rd_en_o = rd_en_q;
   assign tx_serial    = tx_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: two drains (8N1 @434 and 8N2 @4) fed by FIFO
// models; a line-level RX model checks every frame against a queue.
module tb_uart_tx_drain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   bit fin[2];

   function automatic void chk(
      input bit    ok,
      input string nm,
      input int    act,
      input int    req
   );
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
   endfunction

   // expected line level t cycles after the start-bit edge
   function automatic logic lvl(
      input logic [7:0] b,
      input int         t,
      input int         cpb
   );
      int k;
      k = t / cpb;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_i
      localparam int CPB  = (g == 0) ? 434 : 4;
      localparam int SB   = (g == 0) ? 1 : 2;
      localparam int F    = (1 + 8 + SB) * CPB;
      localparam int NRND = (g == 0) ? 3 : 40;

      logic       rst;
      logic       tx_en;
      logic       tx;
      logic       busy;
      logic       done;
      logic [7:0] q_fifo[$];
      logic [7:0] q_exp[$];
      int         pops = 0;
      int         done_n = 0;
      bit         in_frame = 1'b0;
      bit         bad;
      int         bad_t;
      int         t;
      logic [7:0] cur;

      uart_tx_drain_if #(.DATA_BITS(8)) fif ();

      uart_tx_drain #(
         .CLKS_PER_BIT(CPB),
         .DATA_BITS   (8),
         .STOP_BITS   (SB)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .tx_en_i  (tx_en),
         .fifo     (fif),
         .tx_serial(tx),
         .busy_o   (busy),
         .done_o   (done)
      );

      // FIFO model: data valid the cycle after a pop
      always @(posedge clk) begin
         if (fif.rd_en_o === 1'b1) begin
            chk(q_fifo.size() > 0 && busy === 1'b0,
                $sformatf("c%0d_pop_legal", g),
                q_fifo.size() * 2 + int'(busy), 2);
            if (q_fifo.size() > 0) fif.data_i <= q_fifo.pop_front();
            pops++;
         end
         fif.empty_i <= (q_fifo.size() == 0);
      end

      always @(negedge clk) begin
         if (done === 1'b1) done_n++;
      end

      // RX model: checks every cycle of each frame against the byte
      // at the head of the scoreboard queue
      always @(negedge clk) begin
         if (rst === 1'b1) begin
            in_frame = 1'b0;
         end else if (in_frame) begin
            t++;
            if (t < F) begin
               if (tx !== lvl(cur, t, CPB) || busy !== 1'b1 ||
                   done !== 1'b0) begin
                  if (!bad) bad_t = t;
                  bad = 1'b1;
               end
            end else begin
               chk(!bad, $sformatf("c%0d_frame_%02h_bad_cycle", g, cur),
                   bad ? bad_t : -1, -1);
               chk(done === 1'b1 && busy === 1'b0 && tx === 1'b1,
                   $sformatf("c%0d_frame_end", g),
                   {29'd0, tx, busy, done}, 5);
               in_frame = 1'b0;
            end
         end else if (tx === 1'b0) begin
            in_frame = 1'b1;
            t        = 0;
            bad      = (busy !== 1'b1 || done !== 1'b0);
            bad_t    = 0;
            if (q_exp.size() == 0) begin
               chk(1'b0, $sformatf("c%0d_unexpected_frame", g), 0, 1);
               cur = 8'h00;
            end else begin
               cur = q_exp.pop_front();
            end
         end else if (done === 1'b1) begin
            chk(1'b0, $sformatf("c%0d_stray_done", g), 1, 0);
         end
      end

      initial begin
         int         p0;
         int         d0;
         int         gap;
         bit         ok;
         logic [7:0] b;

         rst   = 1'b1;
         tx_en = 1'b0;
         repeat (3) @(negedge clk);
         chk(tx === 1'b1 && busy === 1'b0 && done === 1'b0 &&
             fif.rd_en_o === 1'b0, $sformatf("c%0d_reset", g),
             {28'd0, tx, busy, done, fif.rd_en_o}, 8);
         rst   = 1'b0;
         tx_en = 1'b1;

         // enabled but empty: line idle, no pops
         ok = 1'b1;
         for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fif.rd_en_o !== 1'b0) ok = 1'b0;
         end
         chk(ok, $sformatf("c%0d_empty_idle", g), ok, 1);
         chk(pops == 0, $sformatf("c%0d_empty_pops", g), pops, 0);

         // single byte
         p0 = pops;
         d0 = done_n;
         q_fifo.push_back(8'hF2);
         q_exp.push_back(8'hF2);
         ok = 1'b0;
         for (int i = 0; i < F + 100; i++) begin
            @(negedge clk);
            if (q_fifo.size() == 0 && !busy && !in_frame) begin
               ok = 1'b1;
               break;
            end
         end
         repeat (4) @(negedge clk);
         chk(ok, $sformatf("c%0d_f2_finish", g), ok, 1);
         chk(pops - p0 == 1, $sformatf("c%0d_f2_pops", g), pops - p0, 1);
         chk(done_n - d0 == 1, $sformatf("c%0d_f2_done", g),
             done_n - d0, 1);

         // back-to-back pair
         p0 = pops;
         q_fifo.push_back(8'h55);
         q_exp.push_back(8'h55);
         q_fifo.push_back(8'hA3);
         q_exp.push_back(8'hA3);
         ok = 1'b0;
         for (int i = 0; i < F + 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
               ok = 1'b1;
               break;
            end
         end
         chk(ok, $sformatf("c%0d_pair_first_done", g), ok, 1);
         gap = 0;
         while (tx === 1'b1 && gap < 50) begin
            @(negedge clk);
            gap++;
         end
         // start bit follows done_o after three idle cycles
         chk(gap == 4, $sformatf("c%0d_pair_gap", g), gap, 4);
         ok = 1'b0;
         for (int i = 0; i < F + 100; i++) begin
            @(negedge clk);
            if (q_fifo.size() == 0 && !busy && !in_frame) begin
               ok = 1'b1;
               break;
            end
         end
         repeat (4) @(negedge clk);
         chk(ok && pops - p0 == 2, $sformatf("c%0d_pair_pops", g),
             pops - p0, 2);

         // enable gating
         tx_en = 1'b0;
         p0    = pops;
         q_fifo.push_back(8'h3C);
         q_exp.push_back(8'h3C);
         repeat (F) @(negedge clk);
         chk(pops == p0 && tx === 1'b1, $sformatf("c%0d_en_low", g),
             pops - p0, 0);
         tx_en = 1'b1;
         ok    = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
               ok = 1'b1;
               break;
            end
         end
         chk(ok, $sformatf("c%0d_en_start", g), ok, 1);
         repeat (4 * CPB + CPB / 2) @(negedge clk);
         tx_en = 1'b0;
         q_fifo.push_back(8'h99);
         q_exp.push_back(8'h99);
         ok = 1'b0;
         for (int i = 0; i < F + 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
               ok = 1'b1;
               break;
            end
         end
         repeat (20) @(negedge clk);
         chk(ok, $sformatf("c%0d_en_drop_done", g), ok, 1);
         chk(pops - p0 == 1 && q_fifo.size() == 1,
             $sformatf("c%0d_en_drop_pops", g), pops - p0, 1);
         tx_en = 1'b1;
         ok    = 1'b0;
         for (int i = 0; i < F + 100; i++) begin
            @(negedge clk);
            if (q_fifo.size() == 0 && !busy && !in_frame) begin
               ok = 1'b1;
               break;
            end
         end
         repeat (4) @(negedge clk);
         chk(ok && pops - p0 == 2, $sformatf("c%0d_en_resume", g),
             pops - p0, 2);

         // reset mid-frame
         p0 = pops;
         d0 = done_n;
         q_fifo.push_back(8'hFF);
         q_exp.push_back(8'hFF);
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
               ok = 1'b1;
               break;
            end
         end
         chk(ok, $sformatf("c%0d_rst_start", g), ok, 1);
         repeat (6 * CPB + CPB / 2) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         chk(tx === 1'b1 && busy === 1'b0 && done === 1'b0,
             $sformatf("c%0d_rst_abort", g),
             {29'd0, tx, busy, done}, 4);
         rst = 1'b0;
         repeat (F / 4 + 8) @(negedge clk);
         chk(done_n == d0, $sformatf("c%0d_rst_no_done", g),
             done_n - d0, 0);
         b = 8'($urandom);
         q_fifo.push_back(b);
         q_exp.push_back(b);
         ok = 1'b0;
         for (int i = 0; i < F + 100; i++) begin
            @(negedge clk);
            if (q_fifo.size() == 0 && !busy && !in_frame) begin
               ok = 1'b1;
               break;
            end
         end
         repeat (4) @(negedge clk);
         chk(ok && done_n - d0 == 1, $sformatf("c%0d_rst_next", g),
             done_n - d0, 1);

         // random bursts
         p0 = pops;
         d0 = done_n;
         for (int n = 0; n < NRND; n++) begin
            b = 8'($urandom);
            q_fifo.push_back(b);
            q_exp.push_back(b);
            repeat ($urandom_range(F / 2, 0)) @(negedge clk);
         end
         ok = 1'b0;
         for (int i = 0; i < NRND * (F + 10) + F; i++) begin
            @(negedge clk);
            if (q_fifo.size() == 0 && !busy && !in_frame) begin
               ok = 1'b1;
               break;
            end
         end
         repeat (4) @(negedge clk);
         chk(ok, $sformatf("c%0d_rnd_finish", g), ok, 1);
         chk(pops - p0 == NRND, $sformatf("c%0d_rnd_pops", g),
             pops - p0, NRND);
         chk(done_n - d0 == NRND, $sformatf("c%0d_rnd_done", g),
             done_n - d0, NRND);
         chk(q_exp.size() == 0, $sformatf("c%0d_rnd_sb_empty", g),
             q_exp.size(), 0);
         fin[g] = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 150000; i++) begin
         @(negedge clk);
         if (fin[0] && fin[1]) break;
      end
      chk(fin[0] && fin[1], "all_finished",
          int'(fin[0]) + int'(fin[1]), 2);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
